// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store bus controller
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic {
        LD = 1'b0,
        ST = 1'b1
    } lsu_dir_e;

    // Counter width able to hold every value 0..timeout
    function automatic int wdt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_wdt.sv
// rtl/lsu_wdt.sv - bus wait-cycle watchdog, expires on the TIMEOUT-th stalled cycle
module lsu_wdt
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = wdt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The current stalled cycle is the limit-th one when TIMEOUT-1 have already been counted
    assign expired = en && (cnt_q == LIMIT);

    // Next count: clear on bus entry, otherwise count stalled cycles up to the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lsu_bus_ctl.sv
// rtl/lsu_bus_ctl.sv - CPU request to single registered bus transaction; optional watchdog under LSU_TIMEOUT_EN
module lsu_bus_ctl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_ok,
    output logic              mem_err,
    output logic [DATA_W-1:0] lsu_out,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              write,
    output logic              read,
    input  logic              rdy
);

    lsu_state_e        state_q,   state_d;
    lsu_dir_e          dir_q,     dir_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] lsu_out_q, lsu_out_d;
    logic              read_q,    read_d;
    logic              write_q,   write_d;
    logic              mem_ok_q,  mem_ok_d;
    logic              mem_err_q, mem_err_d;
    logic              wdt_expired;

`ifdef LSU_TIMEOUT_EN
    logic wdt_clr;
    logic wdt_en;

    // Count restarts on every capture so each transaction gets the full budget
    assign wdt_clr = (state_q == IDLE) && (mem_read || mem_write);
    assign wdt_en  = (state_q == BUS) && !rdy;

    lsu_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );
`else
    assign wdt_expired = 1'b0;
`endif

    // Next-state and next-output logic; all bus outputs are registered
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        lsu_out_d = lsu_out_q;
        mem_ok_d  = 1'b0;
        mem_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    state_d = BUS;
                    addr_d  = addr_in;
                    // Write has priority when both requests are raised together
                    if (mem_write) begin
                        dir_d   = ST;
                        wdata_d = wdata_in;
                        write_d = 1'b1;
                        read_d  = 1'b0;
                    end else begin
                        dir_d   = LD;
                        wdata_d = '0;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                    end
                end
            end
            BUS: begin
                // rdy takes precedence over a watchdog expiry in the same cycle
                if (rdy) begin
                    if (dir_q == LD) begin
                        lsu_out_d = rdata;
                    end
                    state_d  = DONE;
                    mem_ok_d = 1'b1;
                    addr_d   = '0;
                    wdata_d  = '0;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                end else if (wdt_expired) begin
                    state_d   = DONE;
                    mem_ok_d  = 1'b1;
                    mem_err_d = 1'b1;
                    addr_d    = '0;
                    wdata_d   = '0;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                wdata_d = '0;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= LD;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            lsu_out_q <= '0;
            mem_ok_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            lsu_out_q <= lsu_out_d;
            mem_ok_q  <= mem_ok_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_ok  = mem_ok_q;
    assign mem_err = mem_err_q;
    assign lsu_out = lsu_out_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign read    = read_q;
    assign write   = write_q;

endmodule

// File: doc/lsu_bus_ctl.md
# lsu_bus_ctl

Parametrised load/store unit for the IOP core family. Sits between the core's execute stage and the system bus, and turns a level-held CPU memory request into one registered bus transaction. It holds address, write data and strobe stable until the slave answers with `rdy`, captures read data into a holding register, and returns a one-cycle completion pulse. An optional watchdog aborts transactions the slave never answers.

## Interface
Parameters:
- `ADDR_W`, 16, address width (CPU address register pair and bus address).
- `DATA_W`, 8, data width of CPU operand, `lsu_out` and bus data.
- `TIMEOUT`, 255, bus wait-cycle limit before abort; legal range 1..65535; used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr_in`  in  ADDR_W  CPU address, sampled with the request.
- `wdata_in`  in  DATA_W  CPU store data, sampled with the request.
- `mem_read`  in  1  load request; level, held by CPU until `mem_ok`.
- `mem_write`  in  1  store request; level, held by CPU until `mem_ok`.
- `mem_ok`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  one-cycle abort flag, coincident with `mem_ok`.
- `lsu_out`  out  DATA_W  last successfully loaded data; held between loads.
- `addr`  out  ADDR_W  bus address; 0 when idle.
- `wdata`  out  DATA_W  bus write data; 0 when idle or on a read.
- `rdata`  in  DATA_W  bus read data, valid in the cycle `rdy`=1.
- `write`  out  1  bus write strobe.
- `read`  out  1  bus read strobe.
- `rdy`  in  1  slave completion; meaningful only while `read` or `write` is high.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: if `mem_write` or `mem_read` is high at the edge, register `addr_in` and the direction, plus `wdata_in` for a write, then go to BUS. If both are high, the write wins and the read is ignored.
- BUS: `addr` and the selected strobe come from registers and do not change. `wdata` is driven for writes only. If `rdy`=1, the transfer completes: a read loads `rdata` into `lsu_out`, the strobes drop, and the FSM goes to DONE. If `rdy`=0, the FSM stays in BUS.
- DONE: `mem_ok`=1 for exactly one cycle, then IDLE. The CPU drops its request on the edge at which it sees `mem_ok`, so the same request is never captured twice.
- `lsu_out` changes only on a successful read. It is not changed by writes, aborts or request inputs.
- `addr`, `wdata`, `read` and `write` are all 0 outside BUS.

## Timing
- Reset values: `mem_ok`=0, `mem_err`=0, `lsu_out`=0, `addr`=0, `wdata`=0, `read`=0, `write`=0, FSM=IDLE, watchdog count=0.
- Minimum latency: request high in cycle 0, bus strobe in cycle 1, `rdy`=1 in cycle 1, `mem_ok` in cycle 2. Each cycle with `rdy`=0 adds one cycle.
- Back-to-back requests: a new request can be captured in the cycle after DONE, so the best-case rate is one access per 3 cycles.
- `rst` asserted in any state, including BUS mid-transaction: all outputs take their reset values at the next edge. No `mem_ok` is issued for the aborted access.
- `rdy` seen high in IDLE or DONE is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A watchdog counts BUS cycles that have `rdy`=0.
  - When the count reaches `TIMEOUT`, the strobes drop and the FSM goes to DONE with `mem_ok`=1 and `mem_err`=1. `lsu_out` is unchanged.
  - The counter clears whenever BUS is entered.
  - If `rdy`=1 arrives in the same cycle the limit is reached, `rdy` wins and the transfer completes normally.
- `LSU_TIMEOUT_EN` undefined: there is no counter, BUS waits forever, and `mem_err` is tied to 0.

## Structure
- Shared package `lsu_pkg`:
  - FSM state enum (IDLE/BUS/DONE).
  - Access-direction enum (LD/ST).
  - Function giving the watchdog counter width, `$clog2(TIMEOUT+1)`.
- Sub-module `lsu_wdt`: the watchdog counter.
  - Ports: `clk`, `rst`, `clr`, `en`, `expired`.
  - Instantiated only under `LSU_TIMEOUT_EN`.

## Test plan
- Read with `rdy` high in the first bus cycle: `addr_in`=16'h1234, `mem_read`=1, `rdata`=8'hA5. Required: `read`=1 with `addr`=16'h1234 in cycle 1; `mem_ok` in cycle 2; `lsu_out`=8'hA5 and held afterwards.
- Write with 3 wait cycles: `addr_in`=16'hFFFF, `wdata_in`=8'h3C. Required: `write`/`addr`/`wdata` stable for 4 cycles; `mem_ok` 1 cycle after `rdy`; `lsu_out` unchanged.
- `mem_read` and `mem_write` both high: only a bus write occurs and `read` stays 0 throughout.
- `rst` pulsed while in BUS: next cycle all bus outputs are 0 and `lsu_out`=0; no `mem_ok` is issued; a following read completes normally.
- `LSU_TIMEOUT_EN` with `TIMEOUT`=4 and `rdy` held 0: strobes drop after 4 BUS cycles; `mem_ok`=`mem_err`=1 for one cycle; `lsu_out` unchanged.
- `LSU_TIMEOUT_EN` with `TIMEOUT`=4 and `rdy`=1 on the 4th BUS cycle: normal completion with `mem_err`=0.
